g_regfile_2r1w: RTL
===================

# g_regfile_2r1w

Parametrised two-read/one-write register file for the RISC-V core, the successor of the single-port-pair BSRAM register array. It provides two independent synchronous read ports and one write port, with write-to-read bypass, optional hardwired-zero register 0, and a post-reset clear sequencer, so that the core no longer depends on RAM initialisation values. It sits between the decode stage (read addresses) and the writeback stage (write port), and infers block RAM or distributed RAM.

## Interface
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth is 2^ADDR_W entries.
- ZERO_R0, 1, 1 = entry 0 reads as zero and ignores writes.
- CLEAR_ON_RESET, 1, 1 = zero every entry after reset via the sequencer; 0 = no clear pass.

- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- ready  out  1  high once the block accepts reads and writes.
- rd_en  in  1  read enable shared by both read ports; when low, rd1 and rd2 hold their values.
- ra1  in  ADDR_W  read address, port 1.
- ra2  in  ADDR_W  read address, port 2.
- rd1  out  DATA_W  registered read data, port 1.
- rd2  out  DATA_W  registered read data, port 2.
- we  in  1  write enable.
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.

## Operation
- Storage is not reset. Clearing is performed only by the sequencer.
- FSM states:
  - RST: entered on any edge where reset=1.
  - CLEAR: entered from RST when reset=0 and CLEAR_ON_RESET=1.
  - RUN: entered from RST when reset=0 and CLEAR_ON_RESET=0, or from CLEAR after the last address.
- RST:
  - Clear counter is set to 0; rd1, rd2 and ready are set to 0.
  - Write port is ignored.
- CLEAR:
  - Each cycle writes 0 to the entry at the counter, then increments the counter.
  - After writing entry 2^ADDR_W−1, the counter wraps to 0 and the FSM goes to RUN.
  - External we is ignored; rd1 and rd2 are forced to 0; ready=0.
- RUN (ready=1):
  - Read: on an edge with rd_en=1, rdN <= mem[raN]. Bypass applies if we=1, wa==raN, and (ZERO_R0=0 or wa≠0); in that case rdN <= wd (write-first).
  - Write: on an edge with we=1, mem[wa] <= wd, except when ZERO_R0=1 and wa=0, where the write is dropped.
  - Zero register: with ZERO_R0=1, a read of address 0 returns 0 regardless of storage contents or bypass.
  - Ports are independent: ra1==ra2 is legal and both ports return the same data.
- Reset asserted mid-CLEAR or mid-RUN returns the FSM to RST on that edge; a full clear restarts once reset is released.

## Timing
- Read latency is one cycle: the address is sampled on edge N and the data is valid after edge N until the next enabled read.
- Write latency is one cycle. A read on edge N+1 of an address written on edge N returns the new data. A read on edge N itself returns the new data through the bypass.
- With rd_en=0, rd1 and rd2 hold their values indefinitely, including across writes to the held address (no retroactive update).
- ready timing, with reset low first sampled at edge E1:
  - CLEAR_ON_RESET=1: clear writes occur on E1..E(2^ADDR_W), and ready is 1 after edge E(2^ADDR_W).
  - CLEAR_ON_RESET=0: ready is 1 after E1.
- Reset values: ready=0, rd1=0, rd2=0, FSM=RST, counter=0.
- Throughput: two reads and one write per cycle, with no stalls in RUN.

## Test plan
- Reset and clear (defaults):
  - Stimulus: hold reset 3 cycles, release.
  - Response: ready=0 for exactly 32 edges, then 1. Reads of all 32 addresses return 0x00000000, even with storage pre-loaded with 0xDEADBEEF before reset.
- Basic write/read:
  - Stimulus: write 0x12345678 to x5, then the next cycle ra1=5, ra2=5, rd_en=1.
  - Response: rd1 = rd2 = 0x12345678 one cycle later.
- Bypass:
  - Stimulus: on the same edge, we=1, wa=7, wd=0xA5A5A5A5, ra1=7, ra2=3 (x3 holds 0x11).
  - Response: rd1=0xA5A5A5A5, rd2=0x00000011. The next read of x7 also returns 0xA5A5A5A5.
- Zero register:
  - Stimulus: write 0xFFFFFFFF to x0 with ra1=0 on the same edge, then read x0 again.
  - Response: rd1=0 both times.
  - Repeat with ZERO_R0=0: the bypass gives 0xFFFFFFFF, and the later read also gives 0xFFFFFFFF.
- Hold and reset mid-clear:
  - Stimulus: read x5 (0x12345678), then drop rd_en and write 0x0 to x5.
  - Response: rd1 stays 0x12345678.
  - Stimulus: assert reset at clear counter=10.
  - Response: rd1/rd2/ready go to 0, and ready rises exactly 32 edges after release.
- Parameter sweep:
  - Stimulus: DATA_W=16, ADDR_W=3, CLEAR_ON_RESET=0.
  - Response: ready=1 one edge after reset release. Write 0xBEEF to entry 7 and read it back as 0xBEEF. Address wrap is exercised by writing entries 0..7.

Source files
------------

// File: rtl/g_regfile_2r1w.sv
// g_regfile_2r1w
// Two-read / one-write register file for the RISC-V core.
// Both read ports are registered. A read of the address being written on the
// same edge returns the new data (write-first bypass). Entry 0 can optionally
// be hardwired to zero. After reset, an optional sequencer writes zero to
// every entry, so the core never depends on RAM power-up contents.
//
// Parameters
//   DATA_W         register width in bits
//   ADDR_W         address width, depth = 2**ADDR_W
//   ZERO_R0        1 = entry 0 reads as zero and ignores writes
//   CLEAR_ON_RESET 1 = zero every entry after reset before asserting ready
//
// Ports
//   i_clk          rising-edge clock
//   i_reset        synchronous, active-high reset
//   o_ready        high once reads and writes are accepted
//   i_rd_en        read enable shared by both ports; low holds o_rd1/o_rd2
//   i_ra1, i_ra2   read addresses
//   o_rd1, o_rd2   registered read data
//   i_we           write enable
//   i_wa, i_wd     write address and write data
module g_regfile_2r1w #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter bit ZERO_R0        = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_ready,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_ra1,
    input  logic [ADDR_W-1:0] i_ra2,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wa,
    input  logic [DATA_W-1:0] i_wd
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_RST,
        ST_CLEAR,
        ST_RUN
    } state_e;

    state_e            r_state;
    state_e            w_nextState;
    logic [ADDR_W-1:0] r_clrCnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;

    logic              w_ready;
    logic              w_clrWrite;
    logic              w_extWe;
    logic              w_memWe;
    logic [ADDR_W-1:0] w_memWa;
    logic [DATA_W-1:0] w_memWd;
    logic              w_byp1;
    logic              w_byp2;
    logic              w_zero1;
    logic              w_zero2;
    logic [DATA_W-1:0] w_rdNext1;
    logic [DATA_W-1:0] w_rdNext2;

    // State register. Reset always forces RST, whatever state we were in,
    // so a reset in the middle of a clear pass restarts the whole pass.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. The first clear write (entry 0) happens on the edge
    // that leaves RST, so CLEAR covers entries 1..DEPTH-1 and hands over to
    // RUN once the counter reaches the last address.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_RST:   w_nextState = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            ST_CLEAR: if (r_clrCnt == '1) w_nextState = ST_RUN;
            ST_RUN:   w_nextState = ST_RUN;
            default:  w_nextState = ST_RST;
        endcase
    end

    // Output decode. The clear sequencer owns the write port until RUN, and
    // external writes are dropped in every other state. Writes to entry 0
    // are discarded when it is hardwired to zero.
    always_comb begin
        w_ready    = 1'b0;
        w_clrWrite = 1'b0;
        w_extWe    = 1'b0;
        case (r_state)
            ST_RST:   w_clrWrite = CLEAR_ON_RESET && !i_reset;
            ST_CLEAR: w_clrWrite = !i_reset;
            ST_RUN: begin
                w_ready = 1'b1;
                w_extWe = i_we && !i_reset && !(ZERO_R0 && (i_wa == '0));
            end
            default: begin
                w_ready    = 1'b0;
                w_clrWrite = 1'b0;
                w_extWe    = 1'b0;
            end
        endcase
    end

    assign w_memWe = w_clrWrite || w_extWe;
    assign w_memWa = w_clrWrite ? r_clrCnt : i_wa;
    assign w_memWd = w_clrWrite ? '0 : i_wd;

    // Clear counter: walks every address once per clear pass and wraps back
    // to zero after the last entry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clrCnt <= '0;
        end else if (w_clrWrite) begin
            r_clrCnt <= r_clrCnt + 1'b1;
        end
    end

    // Storage array. It has no reset so it can map onto RAM; only the
    // sequencer ever clears it.
    always_ff @(posedge i_clk) begin
        if (w_memWe) begin
            r_mem[w_memWa] <= w_memWd;
        end
    end

    // Read-data selection. Hardwired zero wins over everything. Otherwise a
    // same-edge write to the read address is forwarded (write-first). w_extWe
    // already excludes the dropped write to entry 0.
    assign w_zero1   = ZERO_R0 && (i_ra1 == '0);
    assign w_zero2   = ZERO_R0 && (i_ra2 == '0);
    assign w_byp1    = w_extWe && (i_wa == i_ra1);
    assign w_byp2    = w_extWe && (i_wa == i_ra2);
    assign w_rdNext1 = w_zero1 ? '0 : (w_byp1 ? i_wd : r_mem[i_ra1]);
    assign w_rdNext2 = w_zero2 ? '0 : (w_byp2 ? i_wd : r_mem[i_ra2]);

    // Read-data registers. Forced to zero outside RUN, updated only on
    // enabled reads, and held otherwise. A later write to a held address
    // therefore does not change the held value.
    always_ff @(posedge i_clk) begin
        if (i_reset || (r_state != ST_RUN)) begin
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else if (i_rd_en) begin
            r_rd1 <= w_rdNext1;
            r_rd2 <= w_rdNext2;
        end
    end

    assign o_ready = w_ready;
    assign o_rd1   = r_rd1;
    assign o_rd2   = r_rd2;

endmodule
